// File: rtl/unified_mem_ctrl.sv
// ============================================================================
//  Module      : unified_mem_ctrl
//  Description : Initiator for a shared instruction+data byte memory. Arbitrates
//                the fetch and data requesters onto one port with 1-cycle latency.
//                Optional macro MISALIGN_TRAP_EN drops misaligned accesses.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module unified_mem_ctrl #(
    parameter int MEM_BYTES = 57,
    parameter int ADDR_W    = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [2:0]        dm_funct3,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic              dm_valid,
    output logic [31:0]       dm_rdata,
    output logic              dm_err,
    output logic              if_stall,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [2:0]        mem_funct3,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata
);

    localparam logic [2:0]        C_F3_WORD   = 3'b010;
    localparam logic [31:0]       C_NOP       = 32'h0000_0013;
    localparam logic [ADDR_W:0]   C_MEM_BYTES = (ADDR_W+1)'(MEM_BYTES);

    typedef enum logic {
        GRANT_FETCH = 1'b0,
        GRANT_DATA  = 1'b1
    } grant_t;

    grant_t      r_last_grant;
    logic        r_if_valid;
    logic [31:0] r_if_instr;
    logic        r_dm_valid;
    logic [31:0] r_dm_rdata;
    logic        r_dm_err;

    logic        w_if_elig;
    logic        w_dm_elig;
    logic        w_if_win;
    logic        w_dm_win;
    logic [1:0]  w_dm_span;
    logic [ADDR_W:0] w_if_last;
    logic [ADDR_W:0] w_dm_last;
    logic        w_if_oor;
    logic        w_dm_oor;
    logic        w_dm_f3_ok;
    logic        w_if_misal;
    logic        w_dm_misal;
    logic        w_if_bad;
    logic        w_dm_bad;
    logic [31:0] w_load_data;

    // Each requester sits out the cycle its valid pulses, giving the other a turn.
    assign w_if_elig = if_req & ~r_if_valid;
    assign w_dm_elig = dm_req & ~r_dm_valid;
    assign w_dm_win  = w_dm_elig & (~w_if_elig | (r_last_grant != GRANT_DATA));
    assign w_if_win  = w_if_elig & ~w_dm_win;
    assign if_stall  = w_if_elig & ~w_if_win;

    always_comb begin
        w_dm_span = 2'd3;
        case (dm_funct3[1:0])
            2'b00:   w_dm_span = 2'd0;
            2'b01:   w_dm_span = 2'd1;
            default: w_dm_span = 2'd3;
        endcase
    end

    // One extra bit so addresses near the top of the space cannot wrap past the limit.
    assign w_if_last = {1'b0, if_addr} + (ADDR_W+1)'(3);
    assign w_dm_last = {1'b0, dm_addr} + {{(ADDR_W-1){1'b0}}, w_dm_span};
    assign w_if_oor  = (w_if_last >= C_MEM_BYTES);
    assign w_dm_oor  = (w_dm_last >= C_MEM_BYTES);

    always_comb begin
        w_dm_f3_ok = 1'b0;
        case (dm_funct3)
            3'b000, 3'b001, 3'b010: w_dm_f3_ok = 1'b1;
            3'b100, 3'b101:         w_dm_f3_ok = ~dm_we;
            default:                w_dm_f3_ok = 1'b0;
        endcase
    end

`ifdef MISALIGN_TRAP_EN
    assign w_if_misal = |if_addr[1:0];
    always_comb begin
        w_dm_misal = 1'b0;
        case (dm_funct3[1:0])
            2'b01:   w_dm_misal = dm_addr[0];
            2'b10:   w_dm_misal = |dm_addr[1:0];
            default: w_dm_misal = 1'b0;
        endcase
    end
`else
    assign w_if_misal = 1'b0;
    assign w_dm_misal = 1'b0;
`endif

    assign w_if_bad = w_if_oor | w_if_misal;
    assign w_dm_bad = w_dm_oor | w_dm_misal | ~w_dm_f3_ok;

    // Port mux: address and width are still presented on a dropped access,
    // only the enables are suppressed.
    always_comb begin
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        mem_addr   = '0;
        mem_funct3 = 3'b000;
        mem_wdata  = 32'h0;
        if (w_dm_win) begin
            mem_read   = ~dm_we & ~w_dm_bad;
            mem_write  =  dm_we & ~w_dm_bad;
            mem_addr   = dm_addr;
            mem_funct3 = dm_funct3;
            mem_wdata  = dm_wdata;
        end else if (w_if_win) begin
            mem_read   = ~w_if_bad;
            mem_addr   = if_addr;
            mem_funct3 = C_F3_WORD;
        end
    end

    // Width/sign handling is idempotent, so a memory that already extends is fine.
    always_comb begin
        w_load_data = 32'h0;
        case (dm_funct3)
            3'b000:  w_load_data = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
            3'b001:  w_load_data = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
            3'b010:  w_load_data = mem_rdata;
            3'b100:  w_load_data = {24'h0, mem_rdata[7:0]};
            3'b101:  w_load_data = {16'h0, mem_rdata[15:0]};
            default: w_load_data = 32'h0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= GRANT_FETCH;
            r_if_valid   <= 1'b0;
            r_if_instr   <= 32'h0;
            r_dm_valid   <= 1'b0;
            r_dm_rdata   <= 32'h0;
            r_dm_err     <= 1'b0;
        end else begin
            r_if_valid <= w_if_win;
            r_dm_valid <= w_dm_win;
            r_dm_err   <= w_dm_win & w_dm_bad;
            if (w_dm_win) begin
                r_last_grant <= GRANT_DATA;
                r_dm_rdata   <= (w_dm_bad | dm_we) ? 32'h0 : w_load_data;
            end else if (w_if_win) begin
                r_last_grant <= GRANT_FETCH;
                r_if_instr   <= w_if_bad ? C_NOP : mem_rdata;
            end
        end
    end

    assign if_valid = r_if_valid;
    assign if_instr = r_if_instr;
    assign dm_valid = r_dm_valid;
    assign dm_rdata = r_dm_rdata;
    assign dm_err   = r_dm_err;

endmodule

`default_nettype wire

// File: tb/tb_unified_mem_ctrl.sv
// ============================================================================
//  Module      : tb_unified_mem_ctrl
//  Description : Directed self-checking bench for unified_mem_ctrl with a
//                57-byte little-endian memory model on the port.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_unified_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [2:0]  dm_funct3 = '0;
    logic [31:0] dm_addr = '0;
    logic [31:0] dm_wdata = '0;
    logic        dm_valid;
    logic [31:0] dm_rdata;
    logic        dm_err;
    logic        if_stall;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int tests = 0;
    int fails = 0;

    logic [7:0] mem [0:56];

    unified_mem_ctrl #(.MEM_BYTES(57), .ADDR_W(32)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_valid(if_valid), .if_instr(if_instr),
        .dm_req(dm_req), .dm_we(dm_we), .dm_funct3(dm_funct3), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_valid(dm_valid), .dm_rdata(dm_rdata), .dm_err(dm_err),
        .if_stall(if_stall), .mem_read(mem_read), .mem_write(mem_write),
        .mem_addr(mem_addr), .mem_funct3(mem_funct3), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Raw little-endian read of four bytes starting at mem_addr.
    always_comb begin
        mem_rdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (mem_addr + 32'(i) < 32'd57)
                mem_rdata[8*i +: 8] = mem[mem_addr + 32'(i)];
        end
    end

    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 57; i++) mem[i] <= 8'h00;
            mem[0]  <= 8'h93; mem[1]  <= 8'h00; mem[2]  <= 8'h50; mem[3]  <= 8'h00;
            mem[8]  <= 8'h44; mem[9]  <= 8'h33; mem[10] <= 8'h22; mem[11] <= 8'h11;
            mem[56] <= 8'h80;
        end else if (mem_write) begin
            for (int i = 0; i < 4; i++) begin
                if ((i == 0 || (i == 1 && mem_funct3[1:0] != 2'b00) || mem_funct3[1:0] == 2'b10)
                    && (mem_addr + 32'(i) < 32'd57))
                    mem[mem_addr + 32'(i)] <= mem_wdata[8*i +: 8];
            end
        end
    end

    task automatic dm_txn(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wd, output logic got, output logic [31:0] rd,
                          output logic err, output logic saw_rd, output logic saw_wr);
        got = 1'b0; rd = '0; err = 1'b0; saw_rd = 1'b0; saw_wr = 1'b0;
        @(negedge clk);
        dm_req = 1'b1; dm_we = we; dm_funct3 = f3; dm_addr = addr; dm_wdata = wd;
        for (int i = 0; i < 8 && !got; i++) begin
            #1;
            saw_rd |= mem_read;
            saw_wr |= mem_write;
            @(posedge clk); #1;
            if (dm_valid) begin
                got = 1'b1; rd = dm_rdata; err = dm_err;
            end else begin
                @(negedge clk);
            end
        end
        @(negedge clk);
        dm_req = 1'b0; dm_we = 1'b0;
    endtask

    task automatic if_txn(input logic [31:0] addr, output logic got,
                          output logic [31:0] instr, output logic saw_rd);
        got = 1'b0; instr = '0; saw_rd = 1'b0;
        @(negedge clk);
        if_req = 1'b1; if_addr = addr;
        for (int i = 0; i < 8 && !got; i++) begin
            #1;
            saw_rd |= mem_read;
            @(posedge clk); #1;
            if (if_valid) begin
                got = 1'b1; instr = if_instr;
            end else begin
                @(negedge clk);
            end
        end
        @(negedge clk);
        if_req = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        tests++; if (if_valid !== 1'b0) begin fails++; $display("FAIL reset_if_valid got %b want 0", if_valid); end
        tests++; if (dm_valid !== 1'b0) begin fails++; $display("FAIL reset_dm_valid got %b want 0", dm_valid); end
        tests++; if (dm_err !== 1'b0) begin fails++; $display("FAIL reset_dm_err got %b want 0", dm_err); end
        tests++; if (if_instr !== 32'h0) begin fails++; $display("FAIL reset_if_instr got %h want 0", if_instr); end
        tests++; if (dm_rdata !== 32'h0) begin fails++; $display("FAIL reset_dm_rdata got %h want 0", dm_rdata); end
        tests++; if ({mem_read, mem_write} !== 2'b00) begin fails++; $display("FAIL reset_port got %b want 00", {mem_read, mem_write}); end
        rst = 1'b0;
    endtask

    task automatic test_fetch();
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'd0;
        #1;
        tests++; if ({mem_read, mem_write} !== 2'b10) begin fails++; $display("FAIL fetch_rd got %b want 10", {mem_read, mem_write}); end
        tests++; if (mem_addr !== 32'd0) begin fails++; $display("FAIL fetch_addr got %h want 0", mem_addr); end
        tests++; if (mem_funct3 !== 3'b010) begin fails++; $display("FAIL fetch_f3 got %b want 010", mem_funct3); end
        tests++; if (if_stall !== 1'b0) begin fails++; $display("FAIL fetch_stall got %b want 0", if_stall); end
        @(posedge clk); #1;
        tests++; if (if_valid !== 1'b1) begin fails++; $display("FAIL fetch_valid got %b want 1", if_valid); end
        tests++; if (if_instr !== 32'h00500093) begin fails++; $display("FAIL fetch_instr got %h want 00500093", if_instr); end
        @(negedge clk);
        if_req = 1'b0;
        @(posedge clk); #1;
        tests++; if (if_valid !== 1'b0) begin fails++; $display("FAIL fetch_pulse got %b want 0", if_valid); end
    endtask

    task automatic test_arbitration();
        @(negedge clk);
        if_req = 1'b1; if_addr = 32'd0;
        dm_req = 1'b1; dm_we = 1'b0; dm_funct3 = 3'b010; dm_addr = 32'd8;
        #1;
        tests++; if (mem_addr !== 32'd8 || mem_read !== 1'b1) begin fails++; $display("FAIL arb_first got addr %h rd %b want 8/1", mem_addr, mem_read); end
        tests++; if (if_stall !== 1'b1) begin fails++; $display("FAIL arb_stall got %b want 1", if_stall); end
        @(posedge clk); #1;
        tests++; if (dm_valid !== 1'b1 || if_valid !== 1'b0) begin fails++; $display("FAIL arb_v1 got dm %b if %b want 1/0", dm_valid, if_valid); end
        tests++; if (dm_rdata !== 32'h11223344) begin fails++; $display("FAIL arb_lw got %h want 11223344", dm_rdata); end
        @(negedge clk); #1;
        tests++; if (mem_addr !== 32'd0 || mem_funct3 !== 3'b010 || if_stall !== 1'b0) begin fails++; $display("FAIL arb_second got addr %h f3 %b stall %b want 0/010/0", mem_addr, mem_funct3, if_stall); end
        @(posedge clk); #1;
        tests++; if (if_valid !== 1'b1 || dm_valid !== 1'b0) begin fails++; $display("FAIL arb_v2 got if %b dm %b want 1/0", if_valid, dm_valid); end
        tests++; if (if_instr !== 32'h00500093) begin fails++; $display("FAIL arb_instr got %h want 00500093", if_instr); end
        @(negedge clk); #1;
        tests++; if (mem_addr !== 32'd8 || mem_read !== 1'b1) begin fails++; $display("FAIL arb_third got addr %h rd %b want 8/1", mem_addr, mem_read); end
        if_req = 1'b0; dm_req = 1'b0;
        @(posedge clk); #1;
        tests++; if (dm_valid !== 1'b0 || if_valid !== 1'b0) begin fails++; $display("FAIL arb_idle got dm %b if %b want 0/0", dm_valid, if_valid); end
    endtask

    task automatic test_store_load();
        logic got, err, srd, swr;
        logic [31:0] rd;
        dm_txn(1'b1, 3'b000, 32'd5, 32'hAABBCCDD, got, rd, err, srd, swr);
        tests++; if (got !== 1'b1 || err !== 1'b0 || rd !== 32'h0 || swr !== 1'b1) begin fails++; $display("FAIL sb got v%b e%b rd %h w%b want 1/0/0/1", got, err, rd, swr); end
        tests++; if (mem[5] !== 8'hDD || mem[6] !== 8'h00) begin fails++; $display("FAIL sb_mem got %h %h want dd 00", mem[5], mem[6]); end
        dm_txn(1'b0, 3'b100, 32'd5, 32'h0, got, rd, err, srd, swr);
        tests++; if (got !== 1'b1 || rd !== 32'h000000DD) begin fails++; $display("FAIL lbu got %h want 000000dd", rd); end
        dm_txn(1'b0, 3'b000, 32'd5, 32'h0, got, rd, err, srd, swr);
        tests++; if (got !== 1'b1 || rd !== 32'hFFFFFFDD) begin fails++; $display("FAIL lb got %h want ffffffdd", rd); end
        dm_txn(1'b0, 3'b001, 32'd8, 32'h0, got, rd, err, srd, swr);
        tests++; if (got !== 1'b1 || rd !== 32'h00003344) begin fails++; $display("FAIL lh got %h want 00003344", rd); end
        dm_txn(1'b0, 3'b101, 32'd10, 32'h0, got, rd, err, srd, swr);
        tests++; if (got !== 1'b1 || rd !== 32'h00001122) begin fails++; $display("FAIL lhu got %h want 00001122", rd); end
        dm_txn(1'b1, 3'b010, 32'd12, 32'h87654321, got, rd, err, srd, swr);
        dm_txn(1'b0, 3'b001, 32'd14, 32'h0, got, rd, err, srd, swr);
        tests++; if (got !== 1'b1 || rd !== 32'hFFFF8765) begin fails++; $display("FAIL sw_lh got %h want ffff8765", rd); end
    endtask

    task automatic test_out_of_range();
        logic got, err, srd, swr;
        logic [31:0] rd;
        dm_txn(1'b0, 3'b010, 32'd55, 32'h0, got, rd, err, srd, swr);
        tests++; if (got !== 1'b1 || err !== 1'b1 || rd !== 32'h0 || srd !== 1'b0) begin fails++; $display("FAIL oor_lw55 got v%b e%b rd %h r%b want 1/1/0/0", got, err, rd, srd); end
        dm_txn(1'b0, 3'b010, 32'd53, 32'h0, got, rd, err, srd, swr);
        tests++; if (got !== 1'b1 || err !== 1'b0 || rd !== 32'h80000000) begin fails++; $display("FAIL edge_lw53 got e%b rd %h want 0/80000000", err, rd); end
        dm_txn(1'b0, 3'b000, 32'd56, 32'h0, got, rd, err, srd, swr);
        tests++; if (err !== 1'b0 || rd !== 32'hFFFFFF80) begin fails++; $display("FAIL edge_lb56 got e%b rd %h want 0/ffffff80", err, rd); end
        dm_txn(1'b0, 3'b001, 32'd56, 32'h0, got, rd, err, srd, swr);
        tests++; if (err !== 1'b1 || rd !== 32'h0 || srd !== 1'b0) begin fails++; $display("FAIL oor_lh56 got e%b rd %h r%b want 1/0/0", err, rd, srd); end
        dm_txn(1'b1, 3'b010, 32'd54, 32'h12345678, got, rd, err, srd, swr);
        tests++; if (err !== 1'b1 || swr !== 1'b0) begin fails++; $display("FAIL oor_sw54 got e%b w%b want 1/0", err, swr); end
        dm_txn(1'b0, 3'b011, 32'd0, 32'h0, got, rd, err, srd, swr);
        tests++; if (got !== 1'b1 || err !== 1'b1 || rd !== 32'h0 || srd !== 1'b0) begin fails++; $display("FAIL bad_f3_ld got v%b e%b rd %h r%b want 1/1/0/0", got, err, rd, srd); end
        dm_txn(1'b1, 3'b100, 32'd20, 32'hFFFFFFFF, got, rd, err, srd, swr);
        tests++; if (err !== 1'b1 || swr !== 1'b0 || mem[20] !== 8'h00) begin fails++; $display("FAIL bad_f3_st got e%b w%b m %h want 1/0/00", err, swr, mem[20]); end
        if_txn(32'd54, got, rd, srd);
        tests++; if (got !== 1'b1 || rd !== 32'h00000013 || srd !== 1'b0) begin fails++; $display("FAIL oor_fetch got v%b %h r%b want 1/00000013/0", got, rd, srd); end
        if_txn(32'd53, got, rd, srd);
        tests++; if (got !== 1'b1 || rd !== 32'h80000000) begin fails++; $display("FAIL edge_fetch got %h want 80000000", rd); end
    endtask

    task automatic test_misalign();
        logic got, err, srd, swr;
        logic [31:0] rd;
        dm_txn(1'b1, 3'b001, 32'd3, 32'h0000BEEF, got, rd, err, srd, swr);
`ifdef MISALIGN_TRAP_EN
        tests++; if (got !== 1'b1 || err !== 1'b1 || swr !== 1'b0) begin fails++; $display("FAIL mis_sh got v%b e%b w%b want 1/1/0", got, err, swr); end
        tests++; if (mem[3] !== 8'h00 || mem[4] !== 8'h00) begin fails++; $display("FAIL mis_mem got %h %h want 00 00", mem[3], mem[4]); end
        if_txn(32'd2, got, rd, srd);
        tests++; if (rd !== 32'h00000013 || srd !== 1'b0) begin fails++; $display("FAIL mis_fetch got %h r%b want 00000013/0", rd, srd); end
`else
        tests++; if (got !== 1'b1 || err !== 1'b0 || swr !== 1'b1) begin fails++; $display("FAIL mis_sh got v%b e%b w%b want 1/0/1", got, err, swr); end
        tests++; if (mem[3] !== 8'hEF || mem[4] !== 8'hBE) begin fails++; $display("FAIL mis_mem got %h %h want ef be", mem[3], mem[4]); end
        if_txn(32'd2, got, rd, srd);
        tests++; if (rd !== 32'hDDBEEF50 || srd !== 1'b1) begin fails++; $display("FAIL mis_fetch got %h r%b want ddbeef50/1", rd, srd); end
`endif
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        dm_req = 1'b1; dm_we = 1'b0; dm_funct3 = 3'b010; dm_addr = 32'd8;
        @(posedge clk); #1;
        tests++; if (dm_valid !== 1'b1 || dm_rdata !== 32'h11223344) begin fails++; $display("FAIL pre_rst got v%b %h want 1/11223344", dm_valid, dm_rdata); end
        #1 rst = 1'b1;
        #1;
        tests++; if (dm_valid !== 1'b0 || dm_rdata !== 32'h0 || dm_err !== 1'b0) begin fails++; $display("FAIL async_dm got v%b %h e%b want 0/0/0", dm_valid, dm_rdata, dm_err); end
        tests++; if (if_valid !== 1'b0 || if_instr !== 32'h0) begin fails++; $display("FAIL async_if got v%b %h want 0/0", if_valid, if_instr); end
        dm_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_arbitration();
        test_store_load();
        test_out_of_range();
        test_misalign();
        test_async_reset();
        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
